apb_master_mc: RTL and testbench

- Parametrised APB4 master with a valid/ready command port, a valid/ready response port, and direct connection to up to SLAVES_NUM slaves.
- Decodes the slave index from the top address bits and drives one-hot PSEL.
- Sequences SETUP/ACCESS with wait states and muxes per-slave PREADY/PRDATA/PSLVERR.
- Adds byte strobes, decode-error and timeout-error reporting. Sits between a bus-bridge or CPU-side request source and the APB slaves.

---
 rtl/apb_mc_pkg.sv | 22 ++
 rtl/apb_rsp_mux.sv | 30 +++
 rtl/apb_master_mc.sv | 155 +++++++++++++++
 tb/tb_apb_master_mc.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mc_pkg.sv
// Shared types and helpers for the multi-slave APB master.
package apb_mc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apbState_e;

  // Error cause encodings, kept for debug visibility.
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_SLV  = 2'd1;
  localparam logic [1:0] ERR_DEC  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  // A single slave still needs one index bit.
  function automatic int calcSelW(input int slaves);
    return (slaves <= 1) ? 1 : $clog2(slaves);
  endfunction

endpackage

// File: rtl/apb_rsp_mux.sv
// Combinational selection of the addressed slave's PREADY/PSLVERR/PRDATA.
module apb_rsp_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int SLAVES_NUM = 4,
  parameter int SEL_W      = 2
) (
  input  logic [SEL_W-1:0]                 idx_i,
  input  logic [SLAVES_NUM-1:0]            pready_i,
  input  logic [SLAVES_NUM-1:0]            pslverr_i,
  input  logic [SLAVES_NUM*DATA_WIDTH-1:0] prdata_i,
  output logic                             ready_o,
  output logic                             err_o,
  output logic [DATA_WIDTH-1:0]            rdata_o
);

  // Compare-and-select keeps X on unselected slaves out of the result.
  always_comb begin
    ready_o = 1'b0;
    err_o   = 1'b0;
    rdata_o = '0;
    for (int i = 0; i < SLAVES_NUM; i++) begin
      if (idx_i == SEL_W'(i)) begin
        ready_o = pready_i[i];
        err_o   = pslverr_i[i];
        rdata_o = prdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/apb_master_mc.sv
// APB4 master: valid/ready command in, valid/ready response out, one-hot PSEL
// to up to SLAVES_NUM slaves with decode-error and timeout reporting.
module apb_master_mc
  import apb_mc_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SLAVES_NUM = 4,
  parameter int SEL_W      = calcSelW(SLAVES_NUM),
  parameter int TIMEOUT    = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]          cmd_strb,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic [SLAVES_NUM-1:0]            PSEL,
  output logic                             PENABLE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [DATA_WIDTH/8-1:0]          PSTRB,
  input  logic [SLAVES_NUM-1:0]            PREADY,
  input  logic [SLAVES_NUM*DATA_WIDTH-1:0] PRDATA,
  input  logic [SLAVES_NUM-1:0]            PSLVERR
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  apbState_e                 state_q;
  logic [SEL_W-1:0]          idx_q;
  logic [CNT_W-1:0]          tmoCnt_q;
  logic [SLAVES_NUM-1:0]     psel_q;
  logic                      penable_q;
  logic [ADDR_WIDTH-1:0]     paddr_q;
  logic                      pwrite_q;
  logic [DATA_WIDTH-1:0]     pwdata_q;
  logic [DATA_WIDTH/8-1:0]   pstrb_q;
  logic                      rspValid_q;
  logic [DATA_WIDTH-1:0]     rspRdata_q;
  logic                      rspErr_q;

  logic [SEL_W-1:0]          cmdIdx_d;
  logic                      selReady;
  logic                      selErr;
  logic [DATA_WIDTH-1:0]     selRdata;

  assign cmdIdx_d  = cmd_addr[ADDR_WIDTH-1 -: SEL_W];
  assign cmd_ready = (state_q == IDLE) && !PRESET;

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign rsp_valid = rspValid_q;
  assign rsp_rdata = rspRdata_q;
  assign rsp_err   = rspErr_q;

  apb_rsp_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .SLAVES_NUM (SLAVES_NUM),
    .SEL_W      (SEL_W)
  ) u_rspMux (
    .idx_i     (idx_q),
    .pready_i  (PREADY),
    .pslverr_i (PSLVERR),
    .prdata_i  (PRDATA),
    .ready_o   (selReady),
    .err_o     (selErr),
    .rdata_o   (selRdata)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      tmoCnt_q   <= '0;
      psel_q     <= '0;
      penable_q  <= 1'b0;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
      rspValid_q <= 1'b0;
      rspRdata_q <= '0;
      rspErr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            paddr_q  <= cmd_addr;
            pwrite_q <= cmd_write;
            pwdata_q <= cmd_wdata;
            pstrb_q  <= cmd_write ? cmd_strb : '0;
            idx_q    <= cmdIdx_d;
            tmoCnt_q <= '0;
            if (int'(cmdIdx_d) < SLAVES_NUM) begin
              psel_q  <= SLAVES_NUM'(1) << cmdIdx_d;
              state_q <= SETUP;
            end else begin
              // Unmapped slave index: answer with an error, bus stays idle.
              rspErr_q   <= 1'b1;
              rspRdata_q <= '0;
              rspValid_q <= 1'b1;
              state_q    <= RESP;
            end
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // PREADY has priority over a timeout landing in the same cycle.
          if (selReady) begin
            rspErr_q   <= selErr;
            rspRdata_q <= (!pwrite_q && !selErr) ? selRdata : '0;
            psel_q     <= '0;
            penable_q  <= 1'b0;
            rspValid_q <= 1'b1;
            tmoCnt_q   <= '0;
            state_q    <= RESP;
          end else if ((TIMEOUT != 0) && (tmoCnt_q == CNT_W'(TIMEOUT - 1))) begin
            rspErr_q   <= 1'b1;
            rspRdata_q <= '0;
            psel_q     <= '0;
            penable_q  <= 1'b0;
            rspValid_q <= 1'b1;
            tmoCnt_q   <= '0;
            state_q    <= RESP;
          end else begin
            tmoCnt_q <= tmoCnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rspValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_mc.sv
// Self-checking bench for apb_master_mc: three slaves (index 3 unmapped),
// scoreboard of expected responses popped when the response handshakes.
module tb_apb_master_mc;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int NS      = 3;
  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [AW-1:0]     cmd_addr;
  logic [DW-1:0]     cmd_wdata;
  logic [DW/8-1:0]   cmd_strb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic [NS-1:0]     PSEL;
  logic              PENABLE;
  logic [AW-1:0]     PADDR;
  logic              PWRITE;
  logic [DW-1:0]     PWDATA;
  logic [DW/8-1:0]   PSTRB;
  logic [NS-1:0]     PREADY;
  logic [NS*DW-1:0]  PRDATA;
  logic [NS-1:0]     PSLVERR;

  rsp_t expQ[$];
  int   errCount   = 0;
  int   checkCount = 0;
  int   rspCount   = 0;

  always #5 PCLK = ~PCLK;

  apb_master_mc #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .SLAVES_NUM (NS),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_strb  (cmd_strb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA),
    .PSLVERR   (PSLVERR)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Pops the scoreboard whenever a response handshake is about to complete.
  always @(negedge PCLK) begin : monitor
    rsp_t exp;
    if (!PRESET && rsp_valid && rsp_ready) begin
      rspCount++;
      checkOutput("rspPending", 64'(expQ.size() != 0), 64'd1);
      if (expQ.size() != 0) begin
        exp = expQ.pop_front();
        checkOutput("rspErr", 64'(rsp_err), 64'(exp.err));
        checkOutput("rspRdata", 64'(rsp_rdata), 64'(exp.rdata));
      end
    end
  end

  // One command end to end; waits = ACCESS cycles with PREADY low before it rises.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input int waits, input logic slvErr,
                               input logic [31:0] slvData);
    int          idx;
    logic        expDec;
    logic        expTmo;
    logic        expErr;
    logic [2:0]  expSel;
    logic [3:0]  expStrb;
    rsp_t        exp;
    idx     = int'(addr[31:30]);
    expDec  = (idx >= NS);
    expTmo  = !expDec && (waits >= TIMEOUT);
    expErr  = expDec || expTmo || slvErr;
    expSel  = expDec ? 3'b000 : 3'(1 << idx);
    expStrb = wr ? strb : 4'h0;
    exp.err   = expErr;
    exp.rdata = (!wr && !expErr) ? slvData : 32'h0;

    @(posedge PCLK); #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    PREADY    = 'x;
    PSLVERR   = 'x;
    PRDATA    = 'x;
    if (!expDec) begin
      PREADY[idx]             = 1'b0;
      PSLVERR[idx]            = slvErr;
      PRDATA[idx*DW +: DW]    = slvData;
    end
    @(negedge PCLK);
    checkOutput("cmdReady", 64'(cmd_ready), 64'd1);
    expQ.push_back(exp);

    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    @(negedge PCLK);
    if (expDec) begin
      checkOutput("decPsel", 64'(PSEL), 64'd0);
      checkOutput("decValid", 64'(rsp_valid), 64'd1);
    end else begin
      checkOutput("setupPsel", 64'(PSEL), 64'(expSel));
      checkOutput("setupPenable", 64'(PENABLE), 64'd0);
      for (int k = 0; k < TIMEOUT; k++) begin
        @(posedge PCLK); #1;
        PREADY[idx] = (k == waits);
        @(negedge PCLK);
        checkOutput("accPenable", 64'(PENABLE), 64'd1);
        checkOutput("accPsel", 64'(PSEL), 64'(expSel));
        checkOutput("accPaddr", 64'(PADDR), 64'(addr));
        checkOutput("accPstrb", 64'(PSTRB), 64'(expStrb));
        if (k == 0) begin
          checkOutput("accPwrite", 64'(PWRITE), 64'(wr));
          checkOutput("accPwdata", 64'(PWDATA), 64'(wdata));
        end
        if (k == waits) break;
      end
      @(posedge PCLK); #1;
      PREADY[idx] = 1'b0;
      @(negedge PCLK);
      checkOutput("respPsel", 64'(PSEL), 64'd0);
      checkOutput("respPenable", 64'(PENABLE), 64'd0);
      checkOutput("respValid", 64'(rsp_valid), 64'd1);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int rspBefore;
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b1;
    PREADY    = '0;
    PRDATA    = '0;
    PSLVERR   = '0;

    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    checkOutput("rstCmdReady", 64'(cmd_ready), 64'd0);
    checkOutput("rstPsel", 64'(PSEL), 64'd0);
    checkOutput("rstPenable", 64'(PENABLE), 64'd0);
    checkOutput("rstRspValid", 64'(rsp_valid), 64'd0);
    checkOutput("rstPaddr", 64'(PADDR), 64'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;

    applyStimulus(1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h1111_1111);
    applyStimulus(1'b0, 32'h8000_0004, 32'h0,         4'hF, 3, 1'b0, 32'h1234_5678);
    applyStimulus(1'b0, 32'h0000_0008, 32'h0,         4'hF, 0, 1'b1, 32'hAAAA_5555);
    applyStimulus(1'b0, 32'hC000_0000, 32'h0,         4'hF, 0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h4000_0020, 32'h0,         4'hF, 40, 1'b0, 32'h7777_7777);
    applyStimulus(1'b0, 32'h8000_0040, 32'h0,         4'hF, 15, 1'b0, 32'hCAFE_F00D);
    applyStimulus(1'b1, 32'h0000_0100, 32'h0102_0304, 4'h5, 1, 1'b0, 32'h5555_5555);

    // Backpressure: response must hold while rsp_ready stays low.
    @(posedge PCLK); #1;
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 32'h8000_0200, 32'h0, 4'hF, 0, 1'b0, 32'h0BAD_F00D);
    for (int c = 0; c < 5; c++) begin
      @(posedge PCLK); #1;
      @(negedge PCLK);
      checkOutput("bpValid", 64'(rsp_valid), 64'd1);
      checkOutput("bpRdata", 64'(rsp_rdata), 64'h0BAD_F00D);
      checkOutput("bpErr", 64'(rsp_err), 64'd0);
      checkOutput("bpCmdReady", 64'(cmd_ready), 64'd0);
    end
    @(posedge PCLK); #1;
    rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    @(negedge PCLK);
    checkOutput("bpReleasedValid", 64'(rsp_valid), 64'd0);
    checkOutput("bpReleasedReady", 64'(cmd_ready), 64'd1);

    // Reset in the middle of ACCESS: transfer is dropped with no response.
    rspBefore = rspCount;
    @(posedge PCLK); #1;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h4000_0004;
    PREADY    = '0;
    PSLVERR   = '0;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    @(posedge PCLK); #1;
    @(negedge PCLK);
    checkOutput("abortPenable", 64'(PENABLE), 64'd1);
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(negedge PCLK);
    checkOutput("abortCmdReady", 64'(cmd_ready), 64'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(negedge PCLK);
    checkOutput("abortPsel", 64'(PSEL), 64'd0);
    checkOutput("abortPenableLow", 64'(PENABLE), 64'd0);
    checkOutput("abortPaddr", 64'(PADDR), 64'd0);
    checkOutput("abortRspValid", 64'(rsp_valid), 64'd0);
    checkOutput("abortIdle", 64'(cmd_ready), 64'd1);
    repeat (4) @(posedge PCLK);
    @(negedge PCLK);
    checkOutput("abortNoRsp", 64'(rspCount), 64'(rspBefore));
    checkOutput("scoreboardDrained", 64'(expQ.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
